// File: rtl/demux1to2_buffered_if.sv
// ---------------------------------------------------------------------------
// demux1to2_buffered_if
// Purpose : bundles the data/handshake signals of demux1to2_buffered so the
//           block and its environment connect through one interface instance.
// Signals : d        - input data word
//           s        - route select (0 -> output 0, 1 -> output 1)
//           valid_in - d/s carry a word offered for transfer
//           ready_in - block accepts the offered word this cycle
//           y0, y1   - head word of FIFO 0 / FIFO 1 (zero when empty)
//           valid0/1 - corresponding FIFO non-empty
//           ready0/1 - downstream consumes the head word
// Modports: master - environment side (drives d, s, valid_in, ready0/1)
//           slave  - demux side (drives ready_in, y0/1, valid0/1)
// ---------------------------------------------------------------------------
interface demux1to2_buffered_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] d;
    logic             s;
    logic             valid_in;
    logic             ready_in;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic             valid0;
    logic             valid1;
    logic             ready0;
    logic             ready1;

    modport master (
        output d, s, valid_in, ready0, ready1,
        input  ready_in, y0, y1, valid0, valid1
    );

    modport slave (
        input  d, s, valid_in, ready0, ready1,
        output ready_in, y0, y1, valid0, valid1
    );
endinterface

// File: rtl/demux1to2_buffered.sv
// ---------------------------------------------------------------------------
// demux1to2_buffered
// Purpose : 1-to-2 demultiplexer with a DEPTH-entry FIFO on each output.
//           An offered word is written into the FIFO chosen by s when that
//           FIFO is not full; each FIFO presents its head word on its own
//           valid/ready output.
// Params  : WIDTH - data width in bits (1..32)
//           DEPTH - entries per output FIFO (power of 2, 2..16)
// Ports   : clk        - rising-edge clock
//           rst        - asynchronous active-high reset
//           bus        - demux1to2_buffered_if.slave (d, s, valid_in,
//                        ready_in, y0/y1, valid0/valid1, ready0/ready1)
//           cnt0, cnt1 - 16-bit saturating delivered-word counters,
//                        present only when DEMUX_COUNT_EN is defined
// Config  : `define DEMUX_COUNT_EN to build the delivery counters.
// ---------------------------------------------------------------------------
module demux1to2_buffered #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    demux1to2_buffered_if.slave    bus
`ifdef DEMUX_COUNT_EN
    ,
    output logic [15:0]            cnt0,
    output logic [15:0]            cnt1
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem    [2][DEPTH];
    logic [PTR_W-1:0] wr_ptr [2];
    logic [PTR_W-1:0] rd_ptr [2];
    logic [CNT_W-1:0] count  [2];

    logic [1:0] full;
    logic [1:0] nonempty;
    logic [1:0] push;
    logic [1:0] pop;

    // Status and handshake decode. ready_in looks only at the occupancy of
    // the selected FIFO as stored, so a full FIFO refuses a word even in a
    // cycle where it is being popped: there is no pass-through path.
    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int i = 0; i < 2; i++) begin
            full[i]     = (count[i] == FULL_CNT);
            nonempty[i] = (count[i] != '0);
        end
        push[0] = bus.valid_in & ~bus.s & ~full[0];
        push[1] = bus.valid_in &  bus.s & ~full[1];
        pop[0]  = nonempty[0] & bus.ready0;
        pop[1]  = nonempty[1] & bus.ready1;
    end

    // Outputs: the head word is forced to zero whenever its FIFO is empty so
    // stale storage never leaks onto y0/y1, including straight after reset.
    assign bus.ready_in = bus.s ? ~full[1] : ~full[0];
    assign bus.valid0   = nonempty[0];
    assign bus.valid1   = nonempty[1];
    assign bus.y0       = nonempty[0] ? mem[0][rd_ptr[0]] : '0;
    assign bus.y1       = nonempty[1] ? mem[1][rd_ptr[1]] : '0;

    // Pointer and occupancy bookkeeping. Pointers are PTR_W bits wide so they
    // wrap modulo DEPTH on their own. Reset clears everything asynchronously,
    // which also discards any buffered words since they become unreachable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Storage array. It carries no reset: occupancy alone decides which
    // entries are live, so the contents never need clearing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= bus.d;
            end
        end
    end

`ifdef DEMUX_COUNT_EN
    // Delivery counters: one step per pop, holding at all-ones rather than
    // wrapping so a long run never reads back as a small count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop[0] && (cnt0 != 16'hFFFF)) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (pop[1] && (cnt1 != 16'hFFFF)) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux1to2_buffered.sv
// ---------------------------------------------------------------------------
// tb_demux1to2_buffered
// Purpose : self-checking bench for demux1to2_buffered (WIDTH=8, DEPTH=4).
//           A queue-based model tracks the words each output must hold; a
//           negedge process compares every output against it each cycle,
//           and directed scenarios add hand-computed literal expectations.
// Config  : build with DEMUX_COUNT_EN defined to also cover the counters.
// ---------------------------------------------------------------------------
module tb_demux1to2_buffered;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] seen0[$];
    logic [7:0] seen1[$];
    int         mcnt0 = 0;
    int         mcnt1 = 0;

    demux1to2_buffered_if #(.WIDTH(WIDTH)) bus ();

`ifdef DEMUX_COUNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    demux1to2_buffered #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef DEMUX_COUNT_EN
        ,
        .cnt0 (cnt0),
        .cnt1 (cnt1)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any miss.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_cnt++;
        if (actual !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle's worth of inputs shortly after a rising edge, so they
    // are stable for the whole cycle and take effect on the following edge.
    task automatic applyStimulus(input logic [7:0] dv, input logic sv,
                                 input logic vin, input logic r0, input logic r1);
        @(posedge clk);
        #2;
        bus.d        = dv;
        bus.s        = sv;
        bus.valid_in = vin;
        bus.ready0   = r0;
        bus.ready1   = r1;
    endtask

    // Reset empties the model at once, matching the asynchronous clear.
    always @(posedge rst) begin
        q0.delete();
        q1.delete();
        mcnt0 = 0;
        mcnt1 = 0;
    end

    // Per-cycle compare, then advance the model by the transfers the current
    // inputs will cause on the next rising edge.
    always @(negedge clk) begin
        checkOutput("valid0", bus.valid0, q0.size() > 0);
        checkOutput("valid1", bus.valid1, q1.size() > 0);
        checkOutput("y0", bus.y0, (q0.size() > 0) ? q0[0] : 8'h00);
        checkOutput("y1", bus.y1, (q1.size() > 0) ? q1[0] : 8'h00);
        checkOutput("ready_in", bus.ready_in,
                    bus.s ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
`ifdef DEMUX_COUNT_EN
        checkOutput("cnt0", cnt0, mcnt0);
        checkOutput("cnt1", cnt1, mcnt1);
`endif
        if (!rst) begin
            automatic bit p0  = (q0.size() > 0) && bus.ready0;
            automatic bit p1  = (q1.size() > 0) && bus.ready1;
            automatic bit acc = bus.valid_in &&
                                (bus.s ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
            if (p0) begin
                seen0.push_back(bus.y0);
                void'(q0.pop_front());
                if (mcnt0 < 65535) mcnt0++;
            end
            if (p1) begin
                seen1.push_back(bus.y1);
                void'(q1.pop_front());
                if (mcnt1 < 65535) mcnt1++;
            end
            if (acc) begin
                if (bus.s) q1.push_back(bus.d);
                else       q0.push_back(bus.d);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    // Directed scenarios.
    initial begin
        bus.d        = '0;
        bus.s        = 1'b0;
        bus.valid_in = 1'b0;
        bus.ready0   = 1'b0;
        bus.ready1   = 1'b0;

        // Reset state.
        @(negedge clk);
        checkOutput("rst_valid0", bus.valid0, 1'b0);
        checkOutput("rst_valid1", bus.valid1, 1'b0);
        checkOutput("rst_y0", bus.y0, 8'h00);
        checkOutput("rst_ready_in", bus.ready_in, 1'b1);

        // Single route, offered on the very first edge after reset release.
        @(posedge clk);
        #2;
        rst          = 1'b0;
        bus.d        = 8'hA5;
        bus.s        = 1'b0;
        bus.valid_in = 1'b1;
        bus.ready0   = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("single_y0", bus.y0, 8'hA5);
        checkOutput("single_valid0", bus.valid0, 1'b1);
        checkOutput("single_valid1", bus.valid1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("single_drained", bus.valid0, 1'b0);
`ifdef DEMUX_COUNT_EN
        checkOutput("single_cnt0", cnt0, 16'd1);
`endif

        // Fill FIFO 1 to full, probe ready_in per select, then drain in order.
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full1_ready_s1", bus.ready_in, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("full1_ready_s0", bus.ready_in, 1'b1);
        applyStimulus(8'h66, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput("fill_order_y1", bus.y1, 32'(i));
        end
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fill_empty_valid1", bus.valid1, 1'b0);

        // Full FIFO 0 popping while a word is offered: refused, then accepted.
        for (int i = 0; i < 4; i++) applyStimulus(8'h20 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h24, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("fullpop_ready", bus.ready_in, 1'b0);
        checkOutput("fullpop_head", bus.y0, 8'h20);
        applyStimulus(8'h24, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fullpop_ready_next", bus.ready_in, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fullpop_refull", bus.ready_in, 1'b0);
        seen0.delete();
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("fullpop_count", seen0.size(), 4);
        for (int k = 0; k < 4 && k < seen0.size(); k++)
            checkOutput("fullpop_order", seen0[k], 8'h21 + 8'(k));

        // Interleaved routing with both outputs always ready.
        seen0.delete();
        seen1.delete();
        for (int i = 0; i < 8; i++) begin
            automatic logic [3:0] iv = 4'(i);
            applyStimulus(8'h10 + 8'(i), iv[0], 1'b1, 1'b1, 1'b1);
        end
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("inter_count0", seen0.size(), 4);
        checkOutput("inter_count1", seen1.size(), 4);
        for (int k = 0; k < 4 && k < seen0.size(); k++)
            checkOutput("inter_y0", seen0[k], 8'h10 + 8'(2 * k));
        for (int k = 0; k < 4 && k < seen1.size(); k++)
            checkOutput("inter_y1", seen1[k], 8'h11 + 8'(2 * k));

        // Reset between edges with three words buffered in FIFO 0.
        applyStimulus(8'h30, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h31, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h32, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_before", bus.y0, 8'h30);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid0", bus.valid0, 1'b0);
        checkOutput("midrst_y0", bus.y0, 8'h00);
        checkOutput("midrst_ready_in", bus.ready_in, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus.ready0 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("midrst_stays_empty", bus.valid0, 1'b0);
        applyStimulus(8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("midrst_new_word", bus.y0, 8'h40);

`ifdef DEMUX_COUNT_EN
        // Counter saturation: stream through output 0 long enough to exceed
        // 65535 pops since the last reset.
        applyStimulus(8'h77, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (65600) @(posedge clk);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        checkOutput("sat_cnt0", cnt0, 16'hFFFF);
        checkOutput("sat_cnt1", cnt1, 16'h0000);
`endif

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/demux1to2_buffered.md
DEMUX1TO2_BUFFERED -- requirements
Module: demux1to2_buffered

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data width in bits (1..32).
REQ-002 SHALL provide parameter DEPTH, default 4, entries per output FIFO (power of 2, 2..16).
REQ-003 SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port d  input  WIDTH  input data word.
REQ-006 SHALL provide port s  input  1  route select: 0 to output 0, 1 to output 1.
REQ-007 SHALL provide port valid_in  input  1  d/s hold a word offered for transfer.
REQ-008 SHALL provide port ready_in  output  1  block accepts the offered word this cycle.
REQ-009 SHALL provide ports y0, y1  output  WIDTH  head word of FIFO 0 / FIFO 1.
REQ-010 SHALL provide ports valid0, valid1  output  1  corresponding FIFO non-empty.
REQ-011 SHALL provide ports ready0, ready1  input  1  downstream consumes head word.
REQ-012 SHALL provide ports cnt0, cnt1  output  16  words delivered on output 0 / 1 (present only per REQ-031).

Function
REQ-013 SHALL accept a word on a rising clk edge iff valid_in=1 and ready_in=1; the word is written to the FIFO selected by s.
REQ-014 SHALL drive ready_in = NOT full(FIFO selected by s), combinationally from s and FIFO state.
REQ-015 SHALL NOT assert ready_in on a full FIFO even when that FIFO pops in the same cycle (no pass-through).
REQ-016 SHALL present an accepted word on yN with validN=1 starting the cycle after acceptance when FIFO N was empty (latency 1 cycle).
REQ-017 SHALL pop FIFO N on a rising edge iff validN=1 and readyN=1.
REQ-018 SHALL deliver words on each output in acceptance order; no ordering is guaranteed between outputs.
REQ-019 SHALL drive yN to all zeros whenever validN=0.
REQ-020 SHALL hold yN stable while validN=1 and readyN=0.
REQ-021 SHALL support simultaneous push and pop on the same non-full, non-empty FIFO with occupancy unchanged.
REQ-022 SHALL support push to one FIFO and pop from the other in the same cycle independently.
REQ-023 SHALL wrap read and write pointers modulo DEPTH; occupancy tracked in log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-024 SHALL ignore d and s when valid_in=0; ready_in remains a function of s only.
REQ-025 SHALL ignore readyN when validN=0 (no underflow, pointers unchanged).

Reset
REQ-026 SHALL, on rst=1, immediately clear both FIFOs' pointers and occupancy without waiting for clk.
REQ-027 SHALL hold valid0=valid1=0, y0=y1=0, ready_in=1 while rst=1.
REQ-028 SHALL discard all buffered words on reset asserted mid-operation; none reappear after deassertion.
REQ-029 SHALL accept a word on the first rising clk edge after rst deasserts.
REQ-030 SHALL clear cnt0 and cnt1 to 0 on reset when present.

Configuration
REQ-031 SHALL compile cnt0/cnt1 ports and counter logic only when macro DEMUX_COUNT_EN is defined.
REQ-032 SHALL, with DEMUX_COUNT_EN, increment cntN by 1 on each pop of FIFO N, saturating at 16'hFFFF.
REQ-033 SHALL, without DEMUX_COUNT_EN, omit cnt0/cnt1 ports entirely; all other behaviour identical.

Verification
REQ-034 SHALL cover single route: WIDTH=8, reset, d=8'hA5 s=0 valid_in=1 one cycle, ready0=1 -> y0=8'hA5 valid0=1 next cycle, valid1 stays 0, cnt0=1.
REQ-035 SHALL cover fill to full: DEPTH=4, ready1=0, push 8'h01..8'h04 with s=1 -> ready_in=0 when s=1, ready_in=1 when s=0; then ready1=1 -> 01,02,03,04 in order.
REQ-036 SHALL cover full with pop: FIFO 0 full, ready0=1, valid_in=1 s=0 -> ready_in=0 that cycle, 1 the next; occupancy returns to 4 after next push.
REQ-037 SHALL cover interleave: alternate s=0/1 for 8'h10..8'h17 with both ready high -> y0 sees 10,12,14,16; y1 sees 11,13,15,17; no loss.
REQ-038 SHALL cover reset mid-operation: 3 words in FIFO 0, assert rst between edges -> valid0=0 and y0=0 immediately; after release valid0 stays 0 until a new push.
REQ-039 SHALL cover counter saturation with DEMUX_COUNT_EN: force 65 537 pops on output 0 -> cnt0=16'hFFFF, cnt1=0.
